// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with active-low 7-segment drive.
// Define BCD_BLANK_EN for leading-zero blanking; otherwise every digit is decoded.

module bin_to_bcd_seq_seg (
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        case (digit)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
        if (blank) seg = 7'b1111111;
    end
endmodule

module bin_to_bcd_seq #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             start,
    input  logic [W-1:0]     bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [4*D-1:0]   bcd,
    output logic [7*D-1:0]   HEX
);
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]     state;
    logic [W-1:0]   sr;
    logic [4*D-1:0] work;
    logic [4*D-1:0] work_adj;
    logic           sticky;
    logic [CW-1:0]  cnt;

    // add-3 correction so each digit carries correctly on the following shift
    always_comb begin
        work_adj = work;
        for (int k = 0; k < D; k++) begin
            if (work[4*k +: 4] >= 4'd5) work_adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            ovf    <= 1'b0;
            bcd    <= '0;
            sr     <= '0;
            work   <= '0;
            sticky <= 1'b0;
            cnt    <= '0;
        end else begin
            busy <= (state == SHIFT);
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sr     <= bin;
                    work   <= '0;
                    sticky <= 1'b0;
                    cnt    <= CW'(W);
                    state  <= SHIFT;
                end
                SHIFT: begin
                    {work, sr} <= {work_adj[4*D-2:0], sr, 1'b0};
                    sticky     <= sticky | work_adj[4*D-1];
                    cnt        <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= DONE;
                end
                DONE: begin
                    bcd   <= work;
                    ovf   <= sticky;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < D; k++) begin : g_dig
        logic blank;
`ifdef BCD_BLANK_EN
        // a digit above the units is dark when it and everything above it is zero
        if (k == 0) begin : g_units
            assign blank = 1'b0;
        end else begin : g_upper
            assign blank = (bcd[4*D-1:4*k] == '0);
        end
`else
        assign blank = 1'b0;
`endif
        bin_to_bcd_seq_seg u_seg (
            .digit (bcd[4*k +: 4]),
            .blank (blank),
            .seg   (HEX[7*k +: 7])
        );
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench: W=8/D=3 and W=7/D=2 converters against an arithmetic decimal model.
module tb_bin_to_bcd_seq;
    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        Resetn, startA, startB;
    logic [7:0]  binA;
    logic [6:0]  binB;
    logic        busyA, doneA, ovfA, busyB, doneB, ovfB;
    logic [11:0] bcdA;
    logic [20:0] hexA;
    logic [7:0]  bcdB;
    logic [13:0] hexB;

    int errs = 0, checks = 0, cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    bin_to_bcd_seq #(.W(8), .D(3)) dut_a (
        .Clock(Clock), .Resetn(Resetn), .start(startA), .bin(binA),
        .busy(busyA), .done(doneA), .ovf(ovfA), .bcd(bcdA), .HEX(hexA));

    bin_to_bcd_seq #(.W(7), .D(2)) dut_b (
        .Clock(Clock), .Resetn(Resetn), .start(startB), .bin(binB),
        .busy(busyB), .done(doneB), .ovf(ovfB), .bcd(bcdB), .HEX(hexB));

    typedef struct {
        logic [11:0] bcd;
        logic        ovf;
        logic [20:0] hex;
        int          acc;
    } exp_t;
    exp_t qa[$], qb[$];

    logic [6:0] segtab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    function automatic void model(input int v, input int dd, output logic [11:0] b,
                                  output logic o, output logic [20:0] h);
        int p = 1, r, dig, pk = 1;
        for (int i = 0; i < dd; i++) p *= 10;
        o = (v >= p);
        r = v % p;
        b = '0;
        h = '0;
        for (int k = 0; k < dd; k++) begin
            dig = r % 10;
            b[4*k +: 4] = 4'(dig);
            h[7*k +: 7] = segtab[dig];
`ifdef BCD_BLANK_EN
            if (k > 0 && (v % p) < pk) h[7*k +: 7] = 7'h7f;
`endif
            r  = r / 10;
            pk = pk * 10;
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    always @(negedge Clock) begin
        exp_t e;
        if (Resetn === 1'b1 && doneA === 1'b1) begin
            if (qa.size() == 0) chk("A unexpected done", 1, 0);
            else begin
                e = qa.pop_front();
                chk("A bcd", 64'(bcdA), 64'(e.bcd));
                chk("A ovf", 64'(ovfA), 64'(e.ovf));
                chk("A hex", 64'(hexA), 64'(e.hex));
                chk("A latency", 64'(cyc - e.acc), 64'd9);
            end
        end
    end

    always @(negedge Clock) begin
        exp_t e;
        if (Resetn === 1'b1 && doneB === 1'b1) begin
            if (qb.size() == 0) chk("B unexpected done", 1, 0);
            else begin
                e = qb.pop_front();
                chk("B bcd", 64'(bcdB), 64'(e.bcd[7:0]));
                chk("B ovf", 64'(ovfB), 64'(e.ovf));
                chk("B hex", 64'(hexB), 64'(e.hex[13:0]));
                chk("B latency", 64'(cyc - e.acc), 64'd8);
            end
        end
    end

    // Issue one conversion, then check busy/done on every cycle up to the done pulse.
    task automatic conv(input bit sel, input int v, input int poke);
        exp_t e;
        int w = sel ? 7 : 8;
        model(v, sel ? 2 : 3, e.bcd, e.ovf, e.hex);
        if (sel) begin binB = 7'(v); startB = 1'b1; end
        else     begin binA = 8'(v); startA = 1'b1; end
        @(posedge Clock); #1;
        e.acc = cyc;
        if (sel) qb.push_back(e); else qa.push_back(e);
        startA = 1'b0;
        startB = 1'b0;
        binA = 8'($urandom);
        binB = 7'($urandom);
        for (int i = 1; i <= w + 1; i++) begin
            if (i == poke) begin binA = 8'd13; startA = 1'b1; end
            @(posedge Clock); #1;
            startA = 1'b0;
            chk(sel ? "B busy" : "A busy", 64'(sel ? busyB : busyA), 64'(i <= w));
            chk(sel ? "B done" : "A done", 64'(sel ? doneB : doneA), 64'(i == w + 1));
        end
    endtask

    initial begin
        logic [11:0] rb;
        logic        ro;
        logic [20:0] rh;
        Resetn = 1'b0; startA = 1'b0; startB = 1'b0; binA = '0; binB = '0;
        repeat (2) @(posedge Clock);
        #1;
        model(0, 3, rb, ro, rh);
        chk("reset busy", 64'(busyA), 0);
        chk("reset done", 64'(doneA), 0);
        chk("reset ovf", 64'(ovfA), 0);
        chk("reset bcd", 64'(bcdA), 0);
        chk("reset hex", 64'(hexA), 64'(rh));
        Resetn = 1'b1;

        conv(0, 255, 0);
        conv(0, 0, 0);
        conv(0, 7, 0);
        conv(1, 100, 0);
        conv(1, 99, 0);
        conv(0, 42, 4);
        conv(0, 13, 0);

        // reset in the middle of a conversion discards it
        binA = 8'd200; startA = 1'b1;
        @(posedge Clock); #1;
        startA = 1'b0;
        repeat (4) @(posedge Clock);
        #1;
        Resetn = 1'b0;
        @(posedge Clock); #1;
        chk("midreset busy", 64'(busyA), 0);
        chk("midreset done", 64'(doneA), 0);
        chk("midreset bcd", 64'(bcdA), 0);
        chk("midreset hex", 64'(hexA), 64'(rh));
        Resetn = 1'b1;
        conv(0, 200, 0);

        for (int n = 0; n < 12; n++) begin
            conv(0, int'($urandom_range(0, 255)), 0);
            conv(1, int'($urandom_range(0, 127)), 0);
        end
        conv(0, 999 % 256, 0);
        conv(1, 127, 0);

        repeat (3) @(posedge Clock);
        #1;
        chk("scoreboard drained", 64'(qa.size() + qb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
